// File: rtl/prog_run_pkg.sv
// Shared types and width helpers for the program run controller.
package prog_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_INIT    = 3'd2,
    ST_LAUNCH  = 3'd3,
    ST_RUN     = 3'd4,
    ST_CHK_RD  = 3'd5,
    ST_CHK_CMP = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

  localparam int unsigned STATE_W = 3;

  // Bits needed to index n entries; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One shared index counter walks the clear, preload and check sequences.
  function automatic int unsigned idx_w(input int unsigned aw,
                                        input int unsigned n_init,
                                        input int unsigned n_check);
    int unsigned w;
    w = aw;
    if (cnt_w(n_init) > w)  w = cnt_w(n_init);
    if (cnt_w(n_check) > w) w = cnt_w(n_check);
    return w;
  endfunction

endpackage

// File: rtl/prog_run_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear has priority.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: next-state defaults to the held value first, so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_run_ctrl.sv
// Run controller: clear/preload data memory, launch the CPU, wait for halt
// under a timeout, then read back and compare result words.
module prog_run_ctrl
  import prog_run_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 8,
  parameter int unsigned N_INIT  = 3,
  parameter int unsigned N_CHECK = 3,
  parameter int unsigned CLR_MEM = 1,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CW      = 16
) (
  input  logic                             CLK,
  input  logic                             Reset,
  input  logic                             go,
  input  logic [N_INIT*AW-1:0]             init_addr,
  input  logic [N_INIT*DW-1:0]             init_data,
  input  logic [N_CHECK*AW-1:0]            chk_addr,
  input  logic [N_CHECK*DW-1:0]            chk_exp,
  output logic                             mem_we,
  output logic [AW-1:0]                    mem_addr,
  output logic [DW-1:0]                    mem_wdata,
  input  logic [DW-1:0]                    mem_rdata,
  output logic                             dut_start,
  input  logic                             dut_halt,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic                             timed_out,
  output logic [$clog2(N_CHECK+1)-1:0]     err_count,
  output logic [cnt_w(N_CHECK)-1:0]        first_fail,
  output logic [CW-1:0]                    cycle_count
);

  localparam int unsigned EW = $clog2(N_CHECK + 1);
  localparam int unsigned FW = cnt_w(N_CHECK);
  localparam int unsigned IW = idx_w(AW, N_INIT, N_CHECK);

  localparam logic [IW-1:0] CLR_LAST  = IW'((1 << AW) - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(N_INIT - 1);
  localparam logic [IW-1:0] CHK_LAST  = IW'(N_CHECK - 1);

  state_e        state_q, state_d;
  logic [EW-1:0] err_q, err_d;
  logic [FW-1:0] ff_q, ff_d;
  logic          to_q, to_d;

  logic [IW-1:0] idx;
  logic          idx_clr, idx_en;
  logic          cyc_clr, cyc_en;
  logic          cyc_hit;

  logic [AW-1:0] init_a, chk_a;
  logic [DW-1:0] init_d, chk_e;

  sat_counter #(.W(IW)) u_idx (
    .clk_i (CLK),
    .rst_i (Reset),
    .clr_i (idx_clr),
    .en_i  (idx_en),
    .cnt_o (idx)
  );

  sat_counter #(.W(CW)) u_cyc (
    .clk_i (CLK),
    .rst_i (Reset),
    .clr_i (cyc_clr),
    .en_i  (cyc_en),
    .cnt_o (cycle_count)
  );

  // The cycle that brings cycle_count up to TIMEOUT is the last RUN cycle.
  assign cyc_hit = (32'(cycle_count) + 32'd1) >= 32'(TIMEOUT);

  always_comb begin
    init_a = '0;
    init_d = '0;
    chk_a  = '0;
    chk_e  = '0;
    for (int k = 0; k < int'(N_INIT); k++) begin
      if (idx == IW'(k)) begin
        init_a = init_addr[k*AW +: AW];
        init_d = init_data[k*DW +: DW];
      end
    end
    for (int k = 0; k < int'(N_CHECK); k++) begin
      if (idx == IW'(k)) begin
        chk_a = chk_addr[k*AW +: AW];
        chk_e = chk_exp[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    ff_d      = ff_q;
    to_d      = to_q;
    idx_clr   = 1'b0;
    idx_en    = 1'b0;
    cyc_clr   = 1'b0;
    cyc_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dut_start = 1'b1;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d = (CLR_MEM != 0) ? ST_CLEAR : ST_INIT;
          idx_clr = 1'b1;
          cyc_clr = 1'b1;
          err_d   = '0;
          ff_d    = '0;
          to_d    = 1'b0;
        end
      end
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = idx[AW-1:0];
        idx_en   = 1'b1;
        if (idx == CLR_LAST) begin
          state_d = ST_INIT;
          idx_clr = 1'b1;
        end
      end
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = init_a;
        mem_wdata = init_d;
        idx_en    = 1'b1;
        if (idx == INIT_LAST) begin
          state_d = ST_LAUNCH;
          idx_clr = 1'b1;
        end
      end
      ST_LAUNCH: begin
        // Halt is not looked at here: it may still be left over from the previous run.
        dut_start = 1'b0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        dut_start = 1'b0;
        cyc_en    = 1'b1;
        if (dut_halt) begin
          state_d = ST_CHK_RD;
        end else if (cyc_hit) begin
          state_d = ST_DONE;
          to_d    = 1'b1;
        end
      end
      ST_CHK_RD: begin
        dut_start = 1'b0;
        mem_addr  = chk_a;
        state_d   = ST_CHK_CMP;
      end
      ST_CHK_CMP: begin
        dut_start = 1'b0;
        mem_addr  = chk_a;
        if (mem_rdata != chk_e) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) ff_d = idx[FW-1:0];
        end
        if (idx == CHK_LAST) begin
          state_d = ST_DONE;
          idx_clr = 1'b1;
        end else begin
          idx_en  = 1'b1;
          state_d = ST_CHK_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
      ff_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      to_q    <= to_d;
    end
  end

  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_q == '0) && !to_q;
  assign timed_out  = to_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: two instances (with and without memory clear), a
// behavioural data memory and CPU model, and a scoreboard of expected run results.
module tb_prog_run_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NI = 3;
  localparam int NC = 3;
  localparam int CW = 16;
  localparam int TO = 50;

  typedef struct {
    logic          pass;
    logic          to;
    logic [1:0]    err;
    logic [1:0]    ff;
    logic [CW-1:0] cyc;
    int            low;
    int            wr;
    int            rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] go = '0;

  logic [NI*AW-1:0] init_addr;
  logic [NI*DW-1:0] init_data;
  logic [NC*AW-1:0] chk_addr;
  logic [NC*DW-1:0] chk_exp;

  logic [1:0]         mem_we, dut_start, dut_halt, busy, done, pass, timed_out;
  logic [1:0][AW-1:0] mem_addr;
  logic [1:0][DW-1:0] mem_wdata, mem_rdata;
  logic [1:0][1:0]    err_count, first_fail;
  logic [1:0][CW-1:0] cycle_count;

  logic [DW-1:0] mem [2][256];
  int lc[2];
  int low_cyc[2];
  int wr_cnt[2];
  int rd_cnt[2];

  int            halt_at  = 0;
  int            wr_cycle = 0;
  logic [DW-1:0] wr_val   = '0;
  logic          stale    = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  prog_run_ctrl #(.DW(DW), .AW(AW), .N_INIT(NI), .N_CHECK(NC), .CLR_MEM(1), .TIMEOUT(TO), .CW(CW)) u_dut_clr (
    .CLK(clk), .Reset(rst), .go(go[0]),
    .init_addr(init_addr), .init_data(init_data), .chk_addr(chk_addr), .chk_exp(chk_exp),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .dut_start(dut_start[0]), .dut_halt(dut_halt[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timed_out(timed_out[0]),
    .err_count(err_count[0]), .first_fail(first_fail[0]), .cycle_count(cycle_count[0])
  );

  prog_run_ctrl #(.DW(DW), .AW(AW), .N_INIT(NI), .N_CHECK(NC), .CLR_MEM(0), .TIMEOUT(TO), .CW(CW)) u_dut_nclr (
    .CLK(clk), .Reset(rst), .go(go[1]),
    .init_addr(init_addr), .init_data(init_data), .chk_addr(chk_addr), .chk_exp(chk_exp),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .dut_start(dut_start[1]), .dut_halt(dut_halt[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timed_out(timed_out[1]),
    .err_count(err_count[1]), .first_fail(first_fail[1]), .cycle_count(cycle_count[1])
  );

  // lc is the number of completed cycles with dut_start low: 0 in LAUNCH, n in RUN cycle n.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      dut_halt[g] = ((halt_at > 0) && (lc[g] >= halt_at)) || (stale && (lc[g] == 0));
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        for (int j = 0; j < 256; j++) mem[g][j] <= 8'hA5;
        lc[g]      <= 0;
        low_cyc[g] <= 0;
        wr_cnt[g]  <= 0;
        rd_cnt[g]  <= 0;
      end else begin
        if (mem_we[g]) mem[g][mem_addr[g]] <= mem_wdata[g];
        if (!dut_start[g] && (wr_cycle > 0) && (lc[g] == wr_cycle)) mem[g][18] <= wr_val;
        lc[g] <= dut_start[g] ? 0 : lc[g] + 1;
        if (go[g] && !busy[g]) begin
          low_cyc[g] <= 0;
          wr_cnt[g]  <= 0;
          rd_cnt[g]  <= 0;
        end else begin
          low_cyc[g] <= low_cyc[g] + (dut_start[g] ? 0 : 1);
          wr_cnt[g]  <= wr_cnt[g] + (mem_we[g] ? 1 : 0);
          rd_cnt[g]  <= rd_cnt[g] + ((!dut_start[g] && (mem_addr[g] != '0)) ? 1 : 0);
        end
      end
      mem_rdata[g] <= mem[g][mem_addr[g]];
    end
  end

  task automatic cfg_std(input logic [DW-1:0] model_val);
    init_addr = {8'd18, 8'd17, 8'd16};
    init_data = {8'h00, 8'h02, 8'h00};
    chk_addr  = {8'd18, 8'd17, 8'd16};
    chk_exp   = {8'h04, 8'h02, 8'h00};
    halt_at   = 20;
    wr_cycle  = 5;
    wr_val    = model_val;
    stale     = 1'b0;
  endtask

  task automatic start_run(input int sel, input exp_t e);
    sb.push_back(e);
    @(negedge clk);
    go[sel] = 1'b1;
    @(negedge clk);
    go[sel] = 1'b0;
  endtask

  task automatic finish_run(input int sel, input string tag);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done[sel]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_wait: got done=%b want done=1 within 3000 cycles", tag, done[sel]);
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue want one entry", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (pass[sel] !== e.pass) begin errors++; $display("FAIL %s pass: got %b want %b", tag, pass[sel], e.pass); end
    checks++;
    if (timed_out[sel] !== e.to) begin errors++; $display("FAIL %s timed_out: got %b want %b", tag, timed_out[sel], e.to); end
    checks++;
    if (err_count[sel] !== e.err) begin errors++; $display("FAIL %s err_count: got %0d want %0d", tag, err_count[sel], e.err); end
    checks++;
    if (first_fail[sel] !== e.ff) begin errors++; $display("FAIL %s first_fail: got %0d want %0d", tag, first_fail[sel], e.ff); end
    checks++;
    if (cycle_count[sel] !== e.cyc) begin errors++; $display("FAIL %s cycle_count: got %0d want %0d", tag, cycle_count[sel], e.cyc); end
    checks++;
    if (low_cyc[sel] != e.low) begin errors++; $display("FAIL %s start_low_cycles: got %0d want %0d", tag, low_cyc[sel], e.low); end
    checks++;
    if (wr_cnt[sel] != e.wr) begin errors++; $display("FAIL %s mem_writes: got %0d want %0d", tag, wr_cnt[sel], e.wr); end
    checks++;
    if (rd_cnt[sel] != e.rd) begin errors++; $display("FAIL %s check_addr_cycles: got %0d want %0d", tag, rd_cnt[sel], e.rd); end
    checks++;
    if ({busy[sel], dut_start[sel], mem_we[sel]} !== 3'b010) begin
      errors++;
      $display("FAIL %s done_state busy/start/we: got %b want 010", tag, {busy[sel], dut_start[sel], mem_we[sel]});
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({dut_start[g], mem_we[g], busy[g], done[g], pass[g], timed_out[g]} !== 6'b100000) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got %b want 100000", g,
                 {dut_start[g], mem_we[g], busy[g], done[g], pass[g], timed_out[g]});
      end
      checks++;
      if ({mem_addr[g], mem_wdata[g]} !== '0) begin
        errors++;
        $display("FAIL reset_mem_bus[%0d]: got addr=%h wdata=%h want 0/0", g, mem_addr[g], mem_wdata[g]);
      end
      checks++;
      if ({err_count[g], first_fail[g], cycle_count[g]} !== '0) begin
        errors++;
        $display("FAIL reset_counts[%0d]: got err=%0d ff=%0d cyc=%0d want 0", g,
                 err_count[g], first_fail[g], cycle_count[g]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_pass();
    cfg_std(8'h04);
    start_run(0, '{pass: 1'b1, to: 1'b0, err: 2'd0, ff: 2'd0, cyc: 16'd20, low: 27, wr: 259, rd: 6});
    checks++;
    if ({busy[0], dut_start[0], mem_we[0]} !== 3'b111) begin
      errors++;
      $display("FAIL pass_clearing: got busy/start/we=%b want 111", {busy[0], dut_start[0], mem_we[0]});
    end
    finish_run(0, "pass");
    checks++;
    if (mem[0][5] !== 8'h00) begin errors++; $display("FAIL pass_mem5_cleared: got %h want 00", mem[0][5]); end
  endtask

  task automatic test_mismatch();
    cfg_std(8'h05);
    start_run(0, '{pass: 1'b0, to: 1'b0, err: 2'd1, ff: 2'd2, cyc: 16'd20, low: 27, wr: 259, rd: 6});
    finish_run(0, "mismatch");
  endtask

  task automatic test_timeout();
    cfg_std(8'h04);
    halt_at  = 0;
    wr_cycle = 0;
    start_run(0, '{pass: 1'b0, to: 1'b1, err: 2'd0, ff: 2'd0, cyc: 16'd50, low: 51, wr: 259, rd: 0});
    finish_run(0, "timeout");
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    cfg_std(8'h04);
    a1 = init_addr[AW +: AW];
    d1 = init_data[DW +: DW];
    @(negedge clk);
    go[1] = 1'b1;
    @(negedge clk);
    go[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_we[1], mem_addr[1], mem_wdata[1]} !== {1'b1, a1, d1}) begin
      errors++;
      $display("FAIL midreset_init_k1: got we=%b addr=%h data=%h want 1/%h/%h", mem_we[1], mem_addr[1], mem_wdata[1], a1, d1);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dut_start[1], mem_we[1], busy[1], done[1]} !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_idle: got start/we/busy/done=%b want 1000", {dut_start[1], mem_we[1], busy[1], done[1]});
    end
    checks++;
    if (mem_addr[1] !== '0) begin errors++; $display("FAIL midreset_addr: got %h want 00", mem_addr[1]); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stale_halt();
    bit hit = 1'b0;
    cfg_std(8'h04);
    halt_at = 8;
    stale   = 1'b1;
    repeat (3) @(negedge clk);
    start_run(0, '{pass: 1'b1, to: 1'b0, err: 2'd0, ff: 2'd0, cyc: 16'd8, low: 15, wr: 259, rd: 6});
    for (int i = 0; i < 1000; i++) begin
      if (lc[0] == 4) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL stale_reach_run4: got lc=%0d want 4 within 1000 cycles", lc[0]); end
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    checks++;
    if ({busy[0], dut_start[0]} !== 2'b10) begin
      errors++;
      $display("FAIL stale_go_ignored: got busy/start=%b want 10", {busy[0], dut_start[0]});
    end
    finish_run(0, "stale_halt");
    stale = 1'b0;
  endtask

  task automatic test_no_clear();
    cfg_std(8'h04);
    init_addr = {8'd17, 8'd16, 8'd16};
    init_data = {8'h02, 8'h22, 8'h11};
    chk_exp   = {8'h04, 8'h02, 8'h22};
    start_run(1, '{pass: 1'b1, to: 1'b0, err: 2'd0, ff: 2'd0, cyc: 16'd20, low: 27, wr: 3, rd: 6});
    finish_run(1, "no_clear");
    checks++;
    if (mem[1][16] !== 8'h22) begin errors++; $display("FAIL noclear_dup_addr16: got %h want 22", mem[1][16]); end
  endtask

  initial begin
    cfg_std(8'h04);
    test_reset();
    test_pass();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    test_stale_halt();
    test_no_clear();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
